// File: rtl/shift_pipe_var.sv
// Pipelined barrel shifter with per-token shift amount and mode, STAGES register stages.
// Optional SHL overflow flag output when SHIFT_PIPE_OVF_EN is defined.
module shift_pipe_var #(
    parameter int N       = 16,
    parameter int SW      = $clog2(N),
    parameter int STAGES  = 2,
    parameter int USE_IMM = 0,
    parameter int I       = 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          en_i,
    input  logic          r_in_i,
    input  logic [2:0]    mode_i,
    input  logic [SW-1:0] s_in_i,
    input  logic [N-1:0]  d_in_i,
    output logic          r_out_o,
    output logic [N-1:0]  d_out_o
`ifdef SHIFT_PIPE_OVF_EN
    ,
    output logic          ovf_o
`endif
);

    localparam int            LPS     = (SW + STAGES - 1) / STAGES;
    localparam logic [SW-1:0] IMM_AMT = SW'(I);

    localparam logic [2:0] MODE_SHL = 3'd0;
    localparam logic [2:0] MODE_SHR = 3'd1;
    localparam logic [2:0] MODE_SRA = 3'd2;
    localparam logic [2:0] MODE_ROL = 3'd3;
    localparam logic [2:0] MODE_ROR = 3'd4;

    function automatic logic [N-1:0] shift_level(input logic [N-1:0] x,
                                                 input logic [2:0]   m,
                                                 input int           sh);
        logic [N-1:0] r;
        case (m)
            MODE_SHL: r = x << sh;
            MODE_SHR: r = x >> sh;
            MODE_SRA: r = (x >> sh) | (x[N-1] ? ~({N{1'b1}} >> sh) : '0);
            MODE_ROL: r = (x << sh) | (x >> (N - sh));
            MODE_ROR: r = (x >> sh) | (x << (N - sh));
            default:  r = x;
        endcase
        return r;
    endfunction

    logic          v_q    [STAGES];
    logic [N-1:0]  dat_q  [STAGES];
    logic [2:0]    mode_q [STAGES];
    logic [SW-1:0] amt_q  [STAGES];

    logic          v_d    [STAGES];
    logic [N-1:0]  dat_d  [STAGES];
    logic [2:0]    mode_d [STAGES];
    logic [SW-1:0] amt_d  [STAGES];

`ifdef SHIFT_PIPE_OVF_EN
    logic          ovf_q  [STAGES];
    logic          ovf_d  [STAGES];
`endif

    // Stage g applies barrel levels g*LPS .. (g+1)*LPS-1 to the token entering it;
    // the last stage simply gets whatever levels remain below SW.
    always_comb begin
        for (int g = 0; g < STAGES; g++) begin
            if (g == 0) begin
                v_d[g]    = r_in_i;
                dat_d[g]  = d_in_i;
                mode_d[g] = mode_i;
                amt_d[g]  = (USE_IMM != 0) ? IMM_AMT : s_in_i;
`ifdef SHIFT_PIPE_OVF_EN
                ovf_d[g]  = 1'b0;
`endif
            end else begin
                v_d[g]    = v_q[g-1];
                dat_d[g]  = dat_q[g-1];
                mode_d[g] = mode_q[g-1];
                amt_d[g]  = amt_q[g-1];
`ifdef SHIFT_PIPE_OVF_EN
                ovf_d[g]  = ovf_q[g-1];
`endif
            end
            for (int k = 0; k < SW; k++) begin
                if ((k / LPS) == g && amt_d[g][k]) begin
`ifdef SHIFT_PIPE_OVF_EN
                    if (mode_d[g] == MODE_SHL && |(dat_d[g] >> (N - (1 << k))))
                        ovf_d[g] = 1'b1;
`endif
                    dat_d[g] = shift_level(dat_d[g], mode_d[g], 1 << k);
                end
            end
        end
    end

    // Payload registers load only behind a valid token, so the output data
    // holds the last real result across bubbles.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int g = 0; g < STAGES; g++) begin
                v_q[g]    <= 1'b0;
                dat_q[g]  <= '0;
                mode_q[g] <= '0;
                amt_q[g]  <= '0;
`ifdef SHIFT_PIPE_OVF_EN
                ovf_q[g]  <= 1'b0;
`endif
            end
        end else if (en_i) begin
            for (int g = 0; g < STAGES; g++) begin
                v_q[g] <= v_d[g];
                if (v_d[g]) begin
                    dat_q[g]  <= dat_d[g];
                    mode_q[g] <= mode_d[g];
                    amt_q[g]  <= amt_d[g];
`ifdef SHIFT_PIPE_OVF_EN
                    ovf_q[g]  <= ovf_d[g];
`endif
                end
            end
        end
    end

    assign r_out_o = v_q[STAGES-1];
    assign d_out_o = dat_q[STAGES-1];
`ifdef SHIFT_PIPE_OVF_EN
    assign ovf_o   = ovf_q[STAGES-1];
`endif

endmodule

// File: tb/tb_shift_pipe_var.sv
// Directed self-checking bench for shift_pipe_var (N=16, STAGES=2), plus an immediate-mode instance.
// Overflow checks are compiled in when SHIFT_PIPE_OVF_EN is defined.
module tb_shift_pipe_var;

    logic        clk_i;
    logic        rst_n_i;
    logic        en_i;
    logic        r_in_i;
    logic [2:0]  mode_i;
    logic [3:0]  s_in_i;
    logic [15:0] d_in_i;
    logic        r_out_o;
    logic [15:0] d_out_o;
    logic        imm_r_out;
    logic [15:0] imm_d_out;
`ifdef SHIFT_PIPE_OVF_EN
    logic        ovf_o;
    logic        imm_ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    shift_pipe_var #(.N(16), .STAGES(2)) u_dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (en_i),
        .r_in_i  (r_in_i),
        .mode_i  (mode_i),
        .s_in_i  (s_in_i),
        .d_in_i  (d_in_i),
        .r_out_o (r_out_o),
        .d_out_o (d_out_o)
`ifdef SHIFT_PIPE_OVF_EN
        ,
        .ovf_o   (ovf_o)
`endif
    );

    shift_pipe_var #(.N(16), .STAGES(2), .USE_IMM(1), .I(3)) u_imm (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (en_i),
        .r_in_i  (r_in_i),
        .mode_i  (mode_i),
        .s_in_i  (s_in_i),
        .d_in_i  (d_in_i),
        .r_out_o (imm_r_out),
        .d_out_o (imm_d_out)
`ifdef SHIFT_PIPE_OVF_EN
        ,
        .ovf_o   (imm_ovf)
`endif
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] m, input logic [3:0] s, input logic [15:0] d);
        r_in_i = r;
        mode_i = m;
        s_in_i = s;
        d_in_i = d;
    endtask

    initial begin
        rst_n_i = 1'b0;
        en_i    = 1'b1;
        drive(1'b0, 3'd0, 4'd0, 16'h0000);
        #1;
        chk("reset_rout", {15'b0, r_out_o}, 16'h0000);
        chk("reset_dout", d_out_o, 16'h0000);
        #2 rst_n_i = 1'b1;

        // single token, latency and hold
        drive(1'b1, 3'd0, 4'd4, 16'h00F1);
        tick();
        drive(1'b0, 3'd0, 4'd0, 16'h0000);
        chk("lat_early_rout", {15'b0, r_out_o}, 16'h0000);
        tick();
        chk("lat_rout", {15'b0, r_out_o}, 16'h0001);
        chk("lat_dout", d_out_o, 16'h0F10);
        tick();
        chk("hold_rout", {15'b0, r_out_o}, 16'h0000);
        chk("hold_dout", d_out_o, 16'h0F10);

        // back-to-back modes
        drive(1'b1, 3'd2, 4'd1, 16'h8001);
        tick();
        drive(1'b1, 3'd1, 4'd1, 16'h8001);
        tick();
        chk("b2b_sra", d_out_o, 16'hC000);
        drive(1'b1, 3'd3, 4'd1, 16'h8001);
        tick();
        chk("b2b_shr", d_out_o, 16'h4000);
        chk("b2b_shr_rout", {15'b0, r_out_o}, 16'h0001);
        drive(1'b1, 3'd4, 4'd4, 16'h8001);
        tick();
        chk("b2b_rol", d_out_o, 16'h0003);
        drive(1'b0, 3'd0, 4'd0, 16'h0000);
        tick();
        chk("b2b_ror", d_out_o, 16'h1800);
        chk("b2b_ror_rout", {15'b0, r_out_o}, 16'h0001);
        tick();
        chk("b2b_end_rout", {15'b0, r_out_o}, 16'h0000);

        // EN freeze with a token in flight; input during freeze is ignored
        drive(1'b1, 3'd0, 4'd2, 16'h0003);
        tick();
        en_i = 1'b0;
        drive(1'b1, 3'd0, 4'd1, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_rout", {15'b0, r_out_o}, 16'h0000);
            chk("frz_dout", d_out_o, 16'h1800);
        end
        en_i = 1'b1;
        drive(1'b0, 3'd0, 4'd0, 16'h0000);
        tick();
        chk("frz_emerge_rout", {15'b0, r_out_o}, 16'h0001);
        chk("frz_emerge_dout", d_out_o, 16'h000C);
        en_i = 1'b0;
        tick();
        chk("frz_out_hold_rout", {15'b0, r_out_o}, 16'h0001);
        en_i = 1'b1;
        tick();
        chk("frz_once_rout", {15'b0, r_out_o}, 16'h0000);
        chk("frz_once_dout", d_out_o, 16'h000C);

        // async reset with two tokens in flight
        drive(1'b1, 3'd0, 4'd1, 16'h0001);
        tick();
        drive(1'b1, 3'd0, 4'd2, 16'h0001);
        tick();
        chk("pre_rst_dout", d_out_o, 16'h0002);
        drive(1'b0, 3'd0, 4'd0, 16'h0000);
        #1 rst_n_i = 1'b0;
        #1;
        chk("rst_rout", {15'b0, r_out_o}, 16'h0000);
        chk("rst_dout", d_out_o, 16'h0000);
        #1 rst_n_i = 1'b1;
        tick();
        chk("post_rst_rout1", {15'b0, r_out_o}, 16'h0000);
        tick();
        chk("post_rst_rout2", {15'b0, r_out_o}, 16'h0000);
        drive(1'b1, 3'd0, 4'd15, 16'h0001);
        tick();
        drive(1'b0, 3'd0, 4'd0, 16'h0000);
        chk("post_rst_rout3", {15'b0, r_out_o}, 16'h0000);
        tick();
        chk("post_rst_new_rout", {15'b0, r_out_o}, 16'h0001);
        chk("post_rst_new_dout", d_out_o, 16'h8000);

        // immediate instance and reserved mode
        drive(1'b1, 3'd0, 4'd7, 16'h0001);
        tick();
        drive(1'b1, 3'd6, 4'd7, 16'h1234);
        tick();
        chk("imm_shl", imm_d_out, 16'h0008);
        chk("var_shl7", d_out_o, 16'h0080);
        drive(1'b0, 3'd0, 4'd0, 16'h0000);
        tick();
        chk("imm_rsvd_dout", imm_d_out, 16'h1234);
        chk("imm_rsvd_rout", {15'b0, imm_r_out}, 16'h0001);
        chk("var_rsvd_dout", d_out_o, 16'h1234);

        // boundaries: SRA by N-1 on negative, zero amount
        drive(1'b1, 3'd2, 4'd15, 16'h8000);
        tick();
        drive(1'b1, 3'd4, 4'd0, 16'h8001);
        tick();
        chk("sra15", d_out_o, 16'hFFFF);
        drive(1'b0, 3'd0, 4'd0, 16'h0000);
        tick();
        chk("ror0", d_out_o, 16'h8001);

`ifdef SHIFT_PIPE_OVF_EN
        drive(1'b1, 3'd0, 4'd4, 16'hF000);
        tick();
        drive(1'b1, 3'd0, 4'd4, 16'h0F00);
        tick();
        chk("ovf_shl_dout", d_out_o, 16'h0000);
        chk("ovf_shl_flag", {15'b0, ovf_o}, 16'h0001);
        drive(1'b1, 3'd3, 4'd4, 16'hF000);
        tick();
        chk("ovf_none_dout", d_out_o, 16'hF000);
        chk("ovf_none_flag", {15'b0, ovf_o}, 16'h0000);
        drive(1'b0, 3'd0, 4'd0, 16'h0000);
        tick();
        chk("ovf_rol_dout", d_out_o, 16'h000F);
        chk("ovf_rol_flag", {15'b0, ovf_o}, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_pipe_var.md
Name: shift_pipe_var

Overview:
- Parametrised successor to the fixed-immediate left-shift dataflow operator.
- Pipelined barrel shifter with a per-token shift amount (or fixed immediate), five shift modes and STAGES register stages.
- Sits in the dataflow operator library; uses the same EN / R_IN / R_OUT token convention as the other operators, so it drops in wherever a shift node is mapped.

Parameters:
- N, 16: data width. Must be a power of two, at least 2.
- SW, $clog2(N): width of S_IN.
- STAGES, 2: pipeline register stages, 1..SW. Also the latency in enabled cycles.
- USE_IMM, 0: 1 = ignore S_IN and shift by I.
- I, 1: immediate shift amount, 0..N-1. Used only when USE_IMM=1.

Ports:
- CLK  in  1  clock; all registers update on the rising edge.
- RST  in  1  asynchronous reset, active-low (0 = reset).
- EN  in  1  global enable; 0 freezes every pipeline register.
- R_IN  in  1  input token valid.
- MODE  in  3  0=SHL, 1=SHR logical, 2=SRA, 3=ROL, 4=ROR, 5..7 reserved.
- S_IN  in  SW  per-token shift amount, unsigned.
- D_IN  in  N  operand.
- R_OUT  out  1  output token valid.
- D_OUT  out  N  result.

Behaviour:
- Reset: on RST=0, immediately (asynchronously) clear all stage valids, stage data, R_OUT and D_OUT. No clock is needed.
- A token is captured on a rising CLK edge when EN=1 and R_IN=1. MODE and S_IN (or I) are sampled together with D_IN and travel down the pipeline with the token.
- Latency:
  - The token appears on D_OUT with R_OUT=1 exactly STAGES enabled edges after capture.
  - Throughput is 1 token per enabled cycle.
  - There is no backpressure; a downstream stall is expressed by dropping EN.
- EN=0 (whole block frozen):
  - All valids, data, mode and amount registers hold.
  - R_OUT and D_OUT hold their last values.
  - Tokens already in flight are neither lost nor duplicated.
- EN=1, R_IN=0: a bubble (valid=0) enters stage 1. Stage data may hold its previous value.
- R_OUT=0 cycles: D_OUT holds the last valid result, not garbage. The output data register loads only when the final-stage valid is 1.
- Barrel structure:
  - SW levels; level k shifts by 2^k when amount bit k is set.
  - Levels are assigned to stages in ascending order, ceil(SW/STAGES) levels per stage; the final stage takes the remainder.
  - STAGES=SW gives one level per stage.
- Mode semantics (amount s, 0..N-1):
  - SHL: zero fill from LSB.
  - SHR: zero fill from MSB.
  - SRA: fill with D_IN[N-1].
  - ROL / ROR: rotate; bits leaving one end re-enter the other.
  - s=0: every mode returns D_IN unchanged.
- Reserved MODE 5..7: result = D_IN unchanged, and the token still propagates with R_OUT=1.
- Reset mid-operation: all in-flight tokens are discarded. The first R_OUT after release belongs to a token captured after release.
- Simultaneous EN=0 and R_IN=1: the input is not captured (EN has priority).

Optional Feature:
- Macro: SHIFT_PIPE_OVF_EN.
- Defined:
  - Adds output OVF (1 bit), reset 0, aligned with R_OUT and held under the same rules as D_OUT.
  - OVF=1 iff MODE=SHL and at least one 1 bit was shifted out past the MSB.
  - Computed as an OR carried through the stages.
  - OVF=0 for all other modes.
- Undefined: no OVF port and no related logic.

Test Plan:
- N=16, STAGES=2, EN=1. R_IN pulse with D_IN=16'h00F1, MODE=0, S_IN=4 -> two edges later R_OUT=1, D_OUT=16'h0F10; next cycle R_OUT=0, D_OUT holds 16'h0F10.
- Back-to-back tokens 16'h8001 under four settings:
  - MODE=2, S=1 -> 16'hC000
  - MODE=1, S=1 -> 16'h4000
  - MODE=3, S=1 -> 16'h0003
  - MODE=4, S=4 -> 16'h1800
  - -> results appear on 4 consecutive cycles in order.
- Token in flight, drop EN for 3 cycles -> R_OUT and D_OUT frozen; after EN returns, result emerges at capture + STAGES enabled edges, exactly once.
- Assert RST=0 between clock edges with 2 tokens in flight -> R_OUT=0 and D_OUT=0 immediately. After release, R_OUT stays 0 until a new token has traversed the pipeline.
- USE_IMM=1, I=3, S_IN=7, D_IN=16'h0001, MODE=0 -> D_OUT=16'h0008. MODE=6 with D_IN=16'h1234 -> D_OUT=16'h1234 with R_OUT=1.
- With SHIFT_PIPE_OVF_EN:
  - SHL of 16'hF000 by 4 -> D_OUT=0, OVF=1.
  - SHL of 16'h0F00 by 4 -> OVF=0.
  - ROL of 16'hF000 by 4 -> OVF=0, D_OUT=16'h000F.
